ro_sequencer: RTL

RO_SEQUENCER -- requirements
Module: ro_sequencer

---
 rtl/ro_pkg.sv | 18 +
 rtl/ro_timeout_cnt.sv | 36 +++
 rtl/ro_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ro_pkg.sv
// ro_pkg -- shared definitions for the ring-buffer readout sequencer.
//
// Contents:
//   ro_state_e          readout FSM state encoding
//   RO_TIMEOUT_CYC_DEF  default SPI completion timeout, in sysclk cycles
package ro_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } ro_state_e;

    localparam logic [15:0] RO_TIMEOUT_CYC_DEF = 16'd4096;

endpackage

// File: rtl/ro_timeout_cnt.sv
// ro_timeout_cnt -- SPI completion watchdog for ro_sequencer.
// Present only when RO_TIMEOUT_EN is defined.
//
// Ports:
//   sysclk   in  clock, rising edge
//   rst      in  synchronous active-high reset
//   run      in  high while the sequencer waits for spi_done_i; low clears
//   expired  out high in the WAIT cycle after which the readout is aborted
//
// The ISSUE cycle that precedes WAIT is counted as cycle 0, so the DONE
// cycle that follows expiry lands LIMIT cycles after spi_start_o.
// LIMIT must be at least 2.
`ifdef RO_TIMEOUT_EN
module ro_timeout_cnt #(
    parameter logic [15:0] LIMIT = 16'd4096
) (
    input  logic sysclk,
    input  logic rst,
    input  logic run,
    output logic expired
);

    logic [15:0] cnt;

    always_ff @(posedge sysclk) begin
        if (rst || !run) begin
            cnt <= 16'd0;
        end else if (!expired) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign expired = run && (cnt == (LIMIT - 16'd2));

endmodule
`endif

// File: rtl/ro_sequencer.sv
// ro_sequencer -- reads a window of words out of a ring buffer and hands
// each one to an SPI shifter, one word at a time.
//
// Optional feature: define RO_TIMEOUT_EN to abort a readout when spi_done_i
// does not arrive within TIMEOUT_CYC cycles of spi_start_o.
//
// Parameters:
//   SIZE         ring-buffer address width
//   TIMEOUT_CYC  SPI completion timeout in sysclk cycles (RO_TIMEOUT_EN only)
//
// Ports:
//   sysclk       in   clock, rising edge
//   rst          in   synchronous active-high reset
//   trig_i       in   readout request
//   offset_i     in   samples back from the write pointer to the first word
//   howmany_i    in   number of words to read
//   wr_addr_i    in   current ring-buffer write pointer
//   spi_done_i   in   pulse: SPI finished the current word (used in WAIT only)
//   rd_addr_o    out  ring-buffer read address (valid in ISSUE/WAIT, 0 otherwise)
//   spi_start_o  out  pulse: word at rd_addr_o valid, start SPI transfer
//   busy_o       out  high from LOAD through DONE
//   done_o       out  pulse at end of readout
//   trig_drop_o  out  pulse: trigger ignored because a readout is running
//   timeout_o    out  pulse, coincident with done_o, when a readout was aborted
//   dbg_state    out  current FSM state
//
// Handshake: spi_start_o is a one-cycle request; the shifter answers with a
// one-cycle spi_done_i pulse, which is only honoured while in WAIT.
module ro_sequencer
    import ro_pkg::*;
#(
    parameter int          SIZE        = 12,
    parameter logic [15:0] TIMEOUT_CYC = RO_TIMEOUT_CYC_DEF
) (
    input  logic            sysclk,
    input  logic            rst,
    input  logic            trig_i,
    input  logic [SIZE-1:0] offset_i,
    input  logic [SIZE-1:0] howmany_i,
    input  logic [SIZE-1:0] wr_addr_i,
    input  logic            spi_done_i,
    output logic [SIZE-1:0] rd_addr_o,
    output logic            spi_start_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            trig_drop_o,
    output logic            timeout_o,
    output ro_state_e       dbg_state
);

    localparam logic [SIZE-1:0] ONE  = {{(SIZE-1){1'b0}}, 1'b1};
    localparam logic [SIZE-1:0] ZERO = '0;

    ro_state_e       state, state_nxt;
    logic [SIZE-1:0] offset_q, howmany_q, wr_addr_q;
    logic [SIZE-1:0] addr_q, remaining_q;
    logic            tmo_expired;

    // ------------------------------------------------------------------
    // Optional watchdog
    // ------------------------------------------------------------------
`ifdef RO_TIMEOUT_EN
    logic timeout_q;

    ro_timeout_cnt #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .sysclk  (sysclk),
        .rst     (rst),
        .run     (state == WAIT),
        .expired (tmo_expired)
    );

    // A late spi_done_i arriving in the expiry cycle still completes the word.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= tmo_expired && !spi_done_i;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign tmo_expired        = 1'b0;
    assign timeout_o          = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state       <= IDLE;
            offset_q    <= ZERO;
            howmany_q   <= ZERO;
            wr_addr_q   <= ZERO;
            addr_q      <= ZERO;
            remaining_q <= ZERO;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    // Snapshot the request so later input changes cannot
                    // disturb a readout in progress.
                    if (trig_i) begin
                        offset_q  <= offset_i;
                        howmany_q <= howmany_i;
                        wr_addr_q <= wr_addr_i;
                    end
                end
                LOAD: begin
                    // The write pointer addresses the next free slot, so the
                    // newest sample sits one below it; arithmetic wraps.
                    addr_q      <= wr_addr_q - offset_q - ONE;
                    remaining_q <= howmany_q;
                end
                WAIT: begin
                    if (spi_done_i) begin
                        addr_q      <= addr_q + ONE;
                        remaining_q <= remaining_q - ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        spi_start_o = 1'b0;
        busy_o      = (state != IDLE);
        done_o      = 1'b0;
        rd_addr_o   = ZERO;
        trig_drop_o = trig_i && (state != IDLE) && !rst;

        case (state)
            IDLE: begin
                if (trig_i) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                // remaining_q is being loaded this cycle, so test the source.
                state_nxt = (howmany_q == ZERO) ? DONE : ISSUE;
            end
            ISSUE: begin
                spi_start_o = 1'b1;
                rd_addr_o   = addr_q;
                state_nxt   = WAIT;
            end
            WAIT: begin
                rd_addr_o = addr_q;
                if (spi_done_i) begin
                    state_nxt = (remaining_q == ONE) ? DONE : ISSUE;
                end else if (tmo_expired) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign dbg_state = state;

endmodule
